// File: rtl/aes_ctr_stream.sv
// CTR-mode stream stage around a fixed-latency pipelined AES core: counter generation,
// plaintext delay line and keystream XOR. Define AES_CTR_WRAP_GUARD_EN to stop at counter wrap.
module aes_ctr_stream #(
  parameter int unsigned LATENCY = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_iv,
  input  logic [127:0] iv,
  input  logic         in_valid,
  input  logic [127:0] in_data,
  output logic         in_ready,
  output logic [127:0] ctr_block,
  input  logic [127:0] core_out,
  output logic         out_valid,
  output logic [127:0] out_data,
  output logic         ctr_exhausted
);

`ifdef AES_CTR_WRAP_GUARD_EN
  typedef enum logic [1:0] {IDLE, RUN, EXH} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t       state_q, state_d;
  logic [127:0] counter_q;
  logic         accept;
  logic [127:0] pt_delay [0:LATENCY];
  logic [LATENCY:0] v_delay;

  always_comb begin
    in_ready = (state_q == RUN) && !load_iv;
    accept   = in_valid && in_ready;
    state_d  = state_q;
    if (load_iv) begin
      state_d = RUN;
    end
`ifdef AES_CTR_WRAP_GUARD_EN
    else if (accept && counter_q[31:0] == '1) begin
      state_d = EXH;
    end
    ctr_exhausted = (state_q == EXH);
`else
    ctr_exhausted = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter: load_iv has priority; accept is already masked by load_iv via in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_q <= '0;
      ctr_block <= '0;
    end else if (load_iv) begin
      counter_q <= iv;
    end else if (accept) begin
      ctr_block        <= counter_q;
      counter_q[31:0]  <= counter_q[31:0] + 32'd1;
    end
  end

  // Plaintext travels alongside the core pipeline so it meets its own keystream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i <= LATENCY; i++) begin
        pt_delay[i] <= '0;
      end
      v_delay   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      pt_delay[0] <= in_data;
      for (int unsigned i = 1; i <= LATENCY; i++) begin
        pt_delay[i] <= pt_delay[i-1];
      end
      v_delay   <= {v_delay[LATENCY-1:0], accept};
      out_valid <= v_delay[LATENCY];
      out_data  <= core_out ^ pt_delay[LATENCY];
    end
  end

endmodule

// File: doc/aes_ctr_stream.md
# aes_ctr_stream

CTR-mode stream stage wrapped around the pipelined AES-256 core (`aes_toplevel` datapath, fixed latency, one block per cycle). Upstream, it generates one 128-bit counter block per accepted plaintext block and drives it into the core. Downstream, it carries the plaintext through a matched delay line and XORs it with the core's keystream output to produce ciphertext with a valid strobe. CTR mode is symmetric, so the same block performs both encryption and decryption.

## Interface
- `LATENCY`, 14: core latency in cycles. A value presented on `ctr_block` right after edge E appears on `core_out` right after edge E+LATENCY. Must be ≥1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `load_iv` input 1: one-cycle pulse that loads `iv` into the counter.
- `iv` input 128: initial counter block (nonce‖counter).
- `in_valid` input 1: `in_data` is valid.
- `in_data` input 128: plaintext or ciphertext block.
- `in_ready` output 1: combinational; block accepts this cycle.
- `ctr_block` output 128: registered counter block to the core input.
- `core_out` input 128: core output (keystream).
- `out_valid` output 1: registered result strobe.
- `out_data` output 128: registered result (`core_out` XOR delayed `in_data`).
- `ctr_exhausted` output 1: counter wrapped. Tied to 0 unless the macro is defined.

## Operation
- **FSM states:** IDLE, RUN, EXH. EXH exists only with the macro.
  - Reset → IDLE.
  - `load_iv` in any state → RUN at the next edge, with counter = `iv`.
- **Ready:** `in_ready = (state==RUN) && !load_iv`. When `load_iv` and `in_valid` are high together, `load_iv` wins and no block is accepted.
- **Accept:** `in_valid && in_ready` at an edge. At that edge:
  - `ctr_block` ← counter.
  - counter[31:0] ← counter[31:0]+1 modulo 2^32; counter[127:32] is unchanged (inc32).
  - `in_data` and a valid bit enter stage 0 of a LATENCY+1-deep shift register.
- **Non-accept edges:** `ctr_block` holds its value, and a 0 valid bit enters the shift register.
- **Output:** at every edge, `out_data` ← `core_out ^ pt_delay[LATENCY]` and `out_valid` ← `v_delay[LATENCY]`. `out_data` updates even when the valid bit is 0; consumers qualify it with `out_valid`.
- **No backpressure on the output side.** Results emerge in acceptance order.
- **In-flight blocks survive `load_iv`:** blocks already accepted drain normally. Only new acceptances use the new counter.
- **Reset values:** state IDLE, counter 0, `ctr_block` 0, all delay-line data and valid bits 0, `out_valid` 0, `out_data` 0, `ctr_exhausted` 0.
- **Reset mid-stream:**
  - All outputs clear immediately, asynchronously.
  - No `out_valid` is produced for blocks accepted before reset.
  - `in_ready` stays 0 until a new `load_iv`.

## Timing
- Block accepted at edge E:
  - `ctr_block` is valid after E.
  - `core_out` carries its keystream after E+LATENCY.
  - `out_valid=1` with `out_data` after edge E+LATENCY+1.
- Total latency is LATENCY+1 cycles.
- Throughput is one block per cycle sustained. N back-to-back accepts give N consecutive `out_valid` cycles.
- `in_ready` is low during the `load_iv` cycle. It is high on the next cycle if the state is RUN.

## Configuration
- **Macro `AES_CTR_WRAP_GUARD_EN`.**
- **Defined:** an accept with counter[31:0]==32'hFFFFFFFF is processed normally. The state then moves to EXH: `in_ready`=0 and `ctr_exhausted`=1. Blocks already in flight still drain. `load_iv` clears `ctr_exhausted` and returns the state to RUN. `ctr_exhausted` is 0 after reset.
- **Undefined:** no EXH state and `ctr_exhausted`=0. The low 32 bits wrap silently to 0 and streaming continues.

## Test plan
Bench uses a behavioural AES-256 core model with LATENCY=14 and key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.

- **SP800-38A F.5.5 vectors:** load iv f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, then stream 6bc1bee2…172a, ae2d8a57…8e51, 30c81c46…52ef, f69f2445…3710 back-to-back.
  - `ctr_block` takes …fcfdfeff, …fcfdff00, …fcfdff01, …fcfdff02.
  - `out_data` = 601ec313775789a5b7a7f504bbf3d228, f443e3ca4d62b59aca84e990cacaf5c5, 2b0930daa23de94ce87017ba2d84988d, dfc9c58db67aada613c2dd08457941a6.
  - `out_valid` is high on 4 consecutive cycles starting 15 cycles after the first accept.
- **Decrypt:** feed the 4 ciphertexts with the same iv → the original plaintexts are recovered.
- **Gaps and ordering:** accepts with idle gaps (valid on cycles 0,3,4) → `out_valid` on cycles 15,18,19 and nothing in between.
- **IDLE and priority:**
  - `in_valid` high before any `load_iv` → `in_ready`=0 and no output.
  - `load_iv` and `in_valid` high in the same cycle → that block is not accepted.
- **Wrap:** load iv with low word FFFFFFFF, then offer 2 blocks.
  - Without the macro: `ctr_block` = …FFFFFFFF, then high96‖00000000.
  - With the macro: one block is accepted, then `ctr_exhausted`=1 and `in_ready`=0 until `load_iv`.
- **Reset mid-stream:** assert `rst_n`=0 with 5 blocks in flight → `out_valid` and `out_data` are 0 immediately. No `out_valid` follows after release, and `in_ready` stays 0 until `load_iv`.
